// File: rtl/score_keeper.sv
// Pong-style score keeper: tracks both scores, times the serve delay in frames
// and sequences IDLE -> SERVE_WAIT -> PLAY -> OVER.
module score_keeper #(
  parameter int unsigned WIN_SCORE    = 11,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync_tick,
  input  logic       ball_out_left,
  input  logic       ball_out_right,
  input  logic       start,
  output logic [3:0] counter_left,
  output logic [3:0] counter_right,
  output logic       serve,
  output logic       serve_dir,
  output logic       game_over,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StServeWait = 2'd1,
    StPlay      = 2'd2,
    StOver      = 2'd3
  } state_e;

  localparam logic [3:0] WinScore    = 4'(WIN_SCORE);
  localparam logic [7:0] ServeFrames = 8'(SERVE_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [3:0] left_q, left_d;
  logic [3:0] right_q, right_d;
  logic       serve_q, serve_d;
  logic       dir_q, dir_d;
  logic       over_q, over_d;

  logic [3:0] left_inc;
  logic [3:0] right_inc;

  // Saturate at the winning score so a counter can never wrap.
  always_comb begin
    left_inc  = (left_q < WinScore) ? left_q + 4'd1 : left_q;
    right_inc = (right_q < WinScore) ? right_q + 4'd1 : right_q;
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    left_d  = left_q;
    right_d = right_q;
    serve_d = 1'b0;
    dir_d   = dir_q;
    over_d  = over_q;

    if (start) begin
      // A restart wins over anything else happening this cycle, in any state.
      state_d = StServeWait;
      timer_d = ServeFrames;
      left_d  = 4'd0;
      right_d = 4'd0;
      dir_d   = 1'b0;
      over_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
        end
        StServeWait: begin
          if (vsync_tick) begin
            if (timer_q <= 8'd1) begin
              timer_d = 8'd0;
              serve_d = 1'b1;
              state_d = StPlay;
            end else begin
              timer_d = timer_q - 8'd1;
            end
          end
        end
        StPlay: begin
          if (ball_out_left && ball_out_right) begin
            state_d = StServeWait;
            timer_d = ServeFrames;
          end else if (ball_out_left) begin
            right_d = right_inc;
            dir_d   = 1'b0;
            if (right_inc == WinScore) begin
              state_d = StOver;
              over_d  = 1'b1;
            end else begin
              state_d = StServeWait;
              timer_d = ServeFrames;
            end
          end else if (ball_out_right) begin
            left_d = left_inc;
            dir_d  = 1'b1;
            if (left_inc == WinScore) begin
              state_d = StOver;
              over_d  = 1'b1;
            end else begin
              state_d = StServeWait;
              timer_d = ServeFrames;
            end
          end
        end
        StOver: begin
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      timer_q <= 8'd0;
      left_q  <= 4'd0;
      right_q <= 4'd0;
      serve_q <= 1'b0;
      dir_q   <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      left_q  <= left_d;
      right_q <= right_d;
      serve_q <= serve_d;
      dir_q   <= dir_d;
      over_q  <= over_d;
    end
  end

  assign counter_left  = left_q;
  assign counter_right = right_q;
  assign serve         = serve_q;
  assign serve_dir     = dir_q;
  assign game_over     = over_q;
  assign state         = state_q;

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with SERVE_FRAMES=3 and WIN_SCORE=11.
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync_tick = 1'b0;
  logic       ball_out_left = 1'b0;
  logic       ball_out_right = 1'b0;
  logic       start = 1'b0;
  logic [3:0] counter_left;
  logic [3:0] counter_right;
  logic       serve;
  logic       serve_dir;
  logic       game_over;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  score_keeper #(
    .WIN_SCORE(11),
    .SERVE_FRAMES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .vsync_tick(vsync_tick),
    .ball_out_left(ball_out_left),
    .ball_out_right(ball_out_right),
    .start(start),
    .counter_left(counter_left),
    .counter_right(counter_right),
    .serve(serve),
    .serve_dir(serve_dir),
    .game_over(game_over),
    .state(state)
  );

  always #5 clk = ~clk;

  // Apply one cycle of inputs; outputs are stable 1ns after the edge on return.
  task automatic cycle(input logic s, input logic bl, input logic br, input logic vs);
    @(negedge clk);
    start = s;
    ball_out_left = bl;
    ball_out_right = br;
    vsync_tick = vs;
    @(posedge clk);
    #1;
    start = 1'b0;
    ball_out_left = 1'b0;
    ball_out_right = 1'b0;
    vsync_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    checks++;
    if ({state, counter_left, counter_right, serve, serve_dir, game_over} !== 13'd0) begin
      errors++;
      $display("FAIL reset_outputs got=%h exp=0",
               {state, counter_left, counter_right, serve, serve_dir, game_over});
    end
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (state !== 2'd0 || counter_left !== 4'd0 || counter_right !== 4'd0) begin
      errors++;
      $display("FAIL idle_hold got state=%0d l=%0d r=%0d exp 0/0/0",
               state, counter_left, counter_right);
    end
  endtask

  task automatic test_serve();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (state !== 2'd1 || serve !== 1'b0 || serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL start_state got state=%0d serve=%0b dir=%0b exp 1/0/0",
               state, serve, serve_dir);
    end
    ticks(2);
    checks++;
    if (serve !== 1'b0 || state !== 2'd1) begin
      errors++;
      $display("FAIL early_serve got serve=%0b state=%0d exp 0/1", serve, state);
    end
    ticks(1);
    checks++;
    if (serve !== 1'b1 || state !== 2'd2 || counter_left !== 4'd0 || counter_right !== 4'd0)
    begin
      errors++;
      $display("FAIL serve_pulse got serve=%0b state=%0d l=%0d r=%0d exp 1/2/0/0",
               serve, state, counter_left, counter_right);
    end
    ticks(1);
    checks++;
    if (serve !== 1'b0 || state !== 2'd2) begin
      errors++;
      $display("FAIL serve_width_play_tick got serve=%0b state=%0d exp 0/2", serve, state);
    end
  endtask

  task automatic test_point_right();
    int serves;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (counter_left !== 4'd1 || serve_dir !== 1'b1 || state !== 2'd1) begin
      errors++;
      $display("FAIL point_right got l=%0d dir=%0b state=%0d exp 1/1/1",
               counter_left, serve_dir, state);
    end
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (counter_right !== 4'd0) begin
      errors++;
      $display("FAIL serve_wait_ignore got r=%0d exp 0", counter_right);
    end
    serves = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (serve === 1'b1) serves++;
    end
    checks++;
    if (serves !== 1) begin
      errors++;
      $display("FAIL serve_count got=%0d exp=1", serves);
    end
  endtask

  task automatic test_point_left();
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (counter_right !== 4'd1 || counter_left !== 4'd1 || serve_dir !== 1'b0 ||
        state !== 2'd1) begin
      errors++;
      $display("FAIL point_left got l=%0d r=%0d dir=%0b state=%0d exp 1/1/0/1",
               counter_left, counter_right, serve_dir, state);
    end
  endtask

  task automatic test_double();
    ticks(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0);
    checks++;
    if (counter_left !== 4'd2 || counter_right !== 4'd1 || state !== 2'd1 ||
        serve_dir !== 1'b1) begin
      errors++;
      $display("FAIL double_out got l=%0d r=%0d state=%0d dir=%0b exp 2/1/1/1",
               counter_left, counter_right, state, serve_dir);
    end
  endtask

  task automatic test_win();
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ticks(3);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    checks++;
    if (counter_left !== 4'd10 || state !== 2'd1 || game_over !== 1'b0) begin
      errors++;
      $display("FAIL left_ten got l=%0d state=%0d go=%0b exp 10/1/0",
               counter_left, state, game_over);
    end
    ticks(3);
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if (counter_left !== 4'd11 || game_over !== 1'b1 || state !== 2'd3) begin
      errors++;
      $display("FAIL win got l=%0d go=%0b state=%0d exp 11/1/3",
               counter_left, game_over, state);
    end
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (counter_left !== 4'd11 || counter_right !== 4'd0 || game_over !== 1'b1 ||
        state !== 2'd3 || serve !== 1'b0) begin
      errors++;
      $display("FAIL over_hold got l=%0d r=%0d go=%0b state=%0d serve=%0b exp 11/0/1/3/0",
               counter_left, counter_right, game_over, state, serve);
    end
    cycle(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if (counter_left !== 4'd0 || counter_right !== 4'd0 || game_over !== 1'b0 ||
        state !== 2'd1 || serve_dir !== 1'b0) begin
      errors++;
      $display("FAIL restart got l=%0d r=%0d go=%0b state=%0d dir=%0b exp 0/0/0/1/0",
               counter_left, counter_right, game_over, state, serve_dir);
    end
  endtask

  task automatic test_start_priority();
    for (int i = 0; i < 5; i++) begin
      ticks(3);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
    end
    for (int i = 0; i < 7; i++) begin
      ticks(3);
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
    end
    ticks(3);
    checks++;
    if (counter_left !== 4'd5 || counter_right !== 4'd7 || state !== 2'd2) begin
      errors++;
      $display("FAIL score_5_7 got l=%0d r=%0d state=%0d exp 5/7/2",
               counter_left, counter_right, state);
    end
    cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (counter_left !== 4'd0 || counter_right !== 4'd0 || state !== 2'd1) begin
      errors++;
      $display("FAIL start_priority got l=%0d r=%0d state=%0d exp 0/0/1",
               counter_left, counter_right, state);
    end
    ticks(2);
    // Start alongside the expiring tick must restart rather than serve.
    cycle(1'b1, 1'b0, 1'b0, 1'b1);
    checks++;
    if (serve !== 1'b0 || state !== 2'd1) begin
      errors++;
      $display("FAIL start_vs_tick got serve=%0b state=%0d exp 0/1", serve, state);
    end
    ticks(2);
    checks++;
    if (serve !== 1'b0) begin
      errors++;
      $display("FAIL reload_early got serve=%0b exp 0", serve);
    end
    ticks(1);
    checks++;
    if (serve !== 1'b1 || state !== 2'd2) begin
      errors++;
      $display("FAIL reload_serve got serve=%0b state=%0d exp 1/2", serve, state);
    end
  endtask

  task automatic test_async_reset();
    int serves;
    cycle(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({state, counter_left, counter_right, serve, serve_dir, game_over} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset got=%h exp=0",
               {state, counter_left, counter_right, serve, serve_dir, game_over});
    end
    #1 reset = 1'b1;
    serves = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1);
      if (serve === 1'b1) serves++;
    end
    checks++;
    if (serves !== 0 || state !== 2'd0) begin
      errors++;
      $display("FAIL post_reset got serves=%0d state=%0d exp 0/0", serves, state);
    end
  endtask

  initial begin
    test_reset();
    test_serve();
    test_point_right();
    test_point_left();
    test_double();
    test_win();
    test_start_priority();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 11, winning score, legal range 1..15.
REQ-002 SHALL have parameter SERVE_FRAMES, default 60, frames between point and serve, legal range 1..255.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port vsync_tick  input  1  one-cycle pulse per frame.
REQ-006 SHALL have port ball_out_left  input  1  one-cycle pulse, ball crossed left edge (right player scores).
REQ-007 SHALL have port ball_out_right  input  1  one-cycle pulse, ball crossed right edge (left player scores).
REQ-008 SHALL have port start  input  1  one-cycle pulse, begin/restart game.
REQ-009 SHALL have port counter_left  output  4  left player score, feeds score display.
REQ-010 SHALL have port counter_right  output  4  right player score, feeds score display.
REQ-011 SHALL have port serve  output  1  one-cycle pulse, launch ball.
REQ-012 SHALL have port serve_dir  output  1  0 = serve toward left, 1 = toward right.
REQ-013 SHALL have port game_over  output  1  high while a winner exists.
REQ-014 SHALL have port state  output  2  IDLE=0, SERVE_WAIT=1, PLAY=2, OVER=3.

Function
REQ-015 All outputs SHALL be registered; no combinational input-to-output path.
REQ-016 IDLE: SHALL hold counters; start -> counters cleared to 0, serve_dir=0, timer=SERVE_FRAMES, next state SERVE_WAIT.
REQ-017 SERVE_WAIT: each vsync_tick SHALL decrement 8-bit timer; vsync_tick with timer==1 -> timer=0, serve=1 for exactly the next cycle, state PLAY on that same edge.
REQ-018 SERVE_WAIT: ball_out_left/ball_out_right SHALL be ignored (no score change).
REQ-019 PLAY: ball_out_left alone -> counter_right+1, serve_dir=0; ball_out_right alone -> counter_left+1, serve_dir=1; update visible cycle after pulse.
REQ-020 PLAY: after increment, score == WIN_SCORE -> state OVER, game_over=1; otherwise state SERVE_WAIT, timer=SERVE_FRAMES.
REQ-021 PLAY: ball_out_left and ball_out_right same cycle -> no score change, serve_dir unchanged, state SERVE_WAIT, timer=SERVE_FRAMES.
REQ-022 PLAY: vsync_tick SHALL have no effect.
REQ-023 OVER: counters and game_over SHALL hold; ball_out/vsync_tick ignored; start -> behaviour of REQ-016, game_over=0.
REQ-024 start in SERVE_WAIT or PLAY SHALL restart per REQ-016; start SHALL win over any simultaneous ball_out or vsync_tick.
REQ-025 Counters SHALL never exceed WIN_SCORE; no wrap.
REQ-026 serve SHALL be 0 on every cycle other than the one defined in REQ-017.

Reset
REQ-027 reset low SHALL immediately force state=IDLE, counter_left=0, counter_right=0, serve=0, serve_dir=0, game_over=0, timer=0, regardless of clock.
REQ-028 Reset asserted mid-SERVE_WAIT or mid-PLAY SHALL abandon the game; no serve pulse after release until a new start.
REQ-029 After reset release, block SHALL remain in IDLE until start.

Verification
REQ-030 Reset, start, SERVE_FRAMES=3, three vsync_tick -> serve high one cycle after third tick, state=2, counters 0/0.
REQ-031 In PLAY, ball_out_right pulse -> counter_left=1, serve_dir=1, state=1; after SERVE_FRAMES ticks serve pulses once.
REQ-032 Left at 10, ball_out_right in PLAY -> counter_left=11, game_over=1, state=3; further ball_out/vsync ignored; start -> 0/0, game_over=0, state=1.
REQ-033 ball_out_left and ball_out_right same cycle in PLAY -> counters unchanged, state=1, serve_dir unchanged.
REQ-034 start coincident with ball_out_left in PLAY at score 5/7 -> counters 0/0, state=1, timer=SERVE_FRAMES.
REQ-035 reset pulsed between clock edges during SERVE_WAIT with timer=2 -> all outputs reset values immediately; no serve on later vsync_ticks.
